vga_pattern_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 41 ++++
 rtl/vga_pattern_gen_if.sv | 21 ++
 rtl/vga_box_mover.sv | 63 ++++++
 rtl/vga_pattern_gen.sv | 111 +++++++++++
 tb/tb_vga_pattern_gen.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared encodings for the VGA pattern generator: mode values, RGB565 colours, pixel width.
package vga_pkg;

    localparam int unsigned PIX_W = 16;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_GRAD  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_e;

    localparam logic [PIX_W-1:0] WHITE   = 16'hFFFF;
    localparam logic [PIX_W-1:0] YELLOW  = 16'hFFE0;
    localparam logic [PIX_W-1:0] CYAN    = 16'h07FF;
    localparam logic [PIX_W-1:0] GREEN   = 16'h07E0;
    localparam logic [PIX_W-1:0] MAGENTA = 16'hF81F;
    localparam logic [PIX_W-1:0] RED     = 16'hF800;
    localparam logic [PIX_W-1:0] BLUE    = 16'h001F;
    localparam logic [PIX_W-1:0] BLACK   = 16'h0000;

    function automatic logic [PIX_W-1:0] bar_colour(input logic [2:0] idx);
        logic [PIX_W-1:0] c;
        unique case (idx)
            3'd0: c = WHITE;
            3'd1: c = YELLOW;
            3'd2: c = CYAN;
            3'd3: c = GREEN;
            3'd4: c = MAGENTA;
            3'd5: c = RED;
            3'd6: c = BLUE;
            3'd7: c = BLACK;
        endcase
        return c;
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel request/response bus between the timing controller (master) and the pattern source.
interface vga_pattern_gen_if;
    logic        Data_Req;
    logic [11:0] H_Addr;
    logic [11:0] V_Addr;
    logic        Frame_Start;
    logic        Mode_Hold;
    logic        Mode_Next;
    logic [15:0] Disp_Data;
    logic [1:0]  Mode;

    modport master (
        output Data_Req, H_Addr, V_Addr, Frame_Start, Mode_Hold, Mode_Next,
        input  Disp_Data, Mode
    );

    modport slave (
        input  Data_Req, H_Addr, V_Addr, Frame_Start, Mode_Hold, Mode_Next,
        output Disp_Data, Mode
    );
endinterface

// File: rtl/vga_box_mover.sv
// Bouncing-box position and direction registers, stepped once per frame_start.
module vga_box_mover #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned BOX_SIZE = 64,
    parameter int unsigned BOX_STEP = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    output logic [11:0] box_x,
    output logic [11:0] box_y
);

    logic [11:0] x_q, x_d, y_q, y_d;
    logic        dx_q, dx_d, dy_q, dy_d;  // 1 = moving towards larger coordinates

    // A blocked move only flips direction; position holds for that frame.
    function automatic logic [12:0] step_axis(input logic [11:0] pos, input logic dir,
                                              input int unsigned limit);
        logic [11:0] p;
        logic        d;
        p = pos;
        d = dir;
        if (dir) begin
            if (32'(pos) + BOX_STEP + BOX_SIZE <= limit) p = pos + 12'(BOX_STEP);
            else d = 1'b0;
        end else begin
            if (32'(pos) >= BOX_STEP) p = pos - 12'(BOX_STEP);
            else d = 1'b1;
        end
        return {d, p};
    endfunction

    always_comb begin
        x_d  = x_q;
        dx_d = dx_q;
        y_d  = y_q;
        dy_d = dy_q;
        if (frame_start) begin
            {dx_d, x_d} = step_axis(x_q, dx_q, H_ACTIVE);
            {dy_d, y_d} = step_axis(y_q, dy_q, V_ACTIVE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q  <= '0;
            y_q  <= '0;
            dx_q <= 1'b1;
            dy_q <= 1'b1;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign box_x = x_q;
    assign box_y = y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: mode FSM plus registered RGB565 pixel mux.
// Define VGA_PAT_BORDER_EN to draw a white one-pixel frame around the active area.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned MODE_FRAMES = 60,
    parameter int unsigned BOX_SIZE    = 64,
    parameter int unsigned BOX_STEP    = 2
) (
    input logic              Clk,
    input logic              Reset,
    vga_pattern_gen_if.slave bus
);

    localparam int unsigned CNT_W = (MODE_FRAMES > 1) ? $clog2(MODE_FRAMES) : 1;
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PIX_W-1:0] disp_q, disp_d;
    logic [11:0]      box_x, box_y;
    logic [11:0]      h, v;

    assign h = bus.H_Addr;
    assign v = bus.V_Addr;

    vga_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box (
        .clk         (Clk),
        .reset       (Reset),
        .frame_start (bus.Frame_Start),
        .box_x       (box_x),
        .box_y       (box_y)
    );

    // Mode_Next takes priority so a coincident rollover advances only once.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        if (bus.Mode_Next) begin
            mode_d = next_mode(mode_q);
            cnt_d  = '0;
        end else if (bus.Frame_Start && !bus.Mode_Hold) begin
            if (cnt_q == CNT_W'(MODE_FRAMES - 1)) begin
                mode_d = next_mode(mode_q);
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    logic [2:0]       bar_idx;
    logic [4:0]       g;
    logic [PIX_W-1:0] grad_pix, check_pix, box_pix, pix;
    logic             pix_valid, box_hit;

    // First bar boundary the column falls below wins; remainder columns stay on bar 7.
    always_comb begin
        bar_idx = 3'd7;
        for (int unsigned i = 0; i < 7; i++) begin
            if (bar_idx == 3'd7 && 32'(h) < (i + 1) * BAR_W) bar_idx = 3'(i);
        end
    end

    assign g         = h[7:3];
    assign grad_pix  = {g, g, g[4], g};
    assign check_pix = (h[5] ^ v[5]) ? WHITE : BLACK;
    assign box_hit   = (h >= box_x) && (32'(h) < 32'(box_x) + BOX_SIZE) &&
                       (v >= box_y) && (32'(v) < 32'(box_y) + BOX_SIZE);
    assign box_pix   = box_hit ? RED : BLUE;
    assign pix_valid = bus.Data_Req && (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);

    always_comb begin
        pix = BLACK;
        unique case (mode_q)
            MODE_BARS:  pix = bar_colour(bar_idx);
            MODE_GRAD:  pix = grad_pix;
            MODE_CHECK: pix = check_pix;
            MODE_BOX:   pix = box_pix;
        endcase
`ifdef VGA_PAT_BORDER_EN
        if (h == 12'd0 || 32'(h) == H_ACTIVE - 1 || v == 12'd0 || 32'(v) == V_ACTIVE - 1) begin
            pix = WHITE;
        end
`endif
        disp_d = pix_valid ? pix : BLACK;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mode_q <= MODE_BARS;
            cnt_q  <= '0;
            disp_q <= BLACK;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            disp_q <= disp_d;
        end
    end

    assign bus.Disp_Data = disp_q;
    assign bus.Mode      = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen against an arithmetic reference model.
module tb_vga_pattern_gen;

    localparam int HA = 800;
    localparam int VA = 480;
    localparam int MF = 3;
    localparam int BS = 64;
    localparam int ST = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_pattern_gen_if bus ();

    vga_pattern_gen #(
        .H_ACTIVE    (HA),
        .V_ACTIVE    (VA),
        .MODE_FRAMES (MF),
        .BOX_SIZE    (BS),
        .BOX_STEP    (ST)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    // Reference state: mode, frame counter, box position and direction (+1/-1).
    int m_mode, m_cnt, m_bx, m_by, m_dx, m_dy;

    logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    endtask

    function automatic logic [15:0] ref_pix(bit req, int h, int v);
        int idx, gv;
        if (!req || h >= HA || v >= VA) return 16'h0000;
`ifdef VGA_PAT_BORDER_EN
        if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) return 16'hFFFF;
`endif
        case (m_mode)
            0: begin
                idx = h / (HA / 8);
                if (idx > 7) idx = 7;
                return bar_tab[idx];
            end
            1: begin
                gv = (h % 256) / 8;
                return {5'(gv), 6'(gv * 2 + gv / 16), 5'(gv)};
            end
            2: return ((h / 32 + v / 32) % 2 == 1) ? 16'hFFFF : 16'h0000;
            default:
                return (h >= m_bx && h < m_bx + BS && v >= m_by && v < m_by + BS) ?
                       16'hF800 : 16'h001F;
        endcase
    endfunction

    task automatic move_axis(inout int pos, inout int dir, input int lim);
        if (dir > 0) begin
            if (pos + ST + BS <= lim) pos = pos + ST;
            else dir = -1;
        end else begin
            if (pos >= ST) pos = pos - ST;
            else dir = 1;
        end
    endtask

    task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock: drive inputs, advance, update the model, compare pixel and mode.
    task automatic cyc(bit req, int h, int v, bit fs, bit hold, bit nx, bit r);
        logic [15:0] exp;
        exp = r ? 16'h0000 : ref_pix(req, h, v);
        rst             = r;
        bus.Data_Req    = req;
        bus.H_Addr      = 12'(h);
        bus.V_Addr      = 12'(v);
        bus.Frame_Start = fs;
        bus.Mode_Hold   = hold;
        bus.Mode_Next   = nx;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            if (nx) begin
                m_mode = (m_mode + 1) % 4;
                m_cnt  = 0;
            end else if (fs && !hold) begin
                if (m_cnt == MF - 1) begin
                    m_mode = (m_mode + 1) % 4;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (fs) begin
                move_axis(m_bx, m_dx, HA);
                move_axis(m_by, m_dy, VA);
            end
        end
        check($sformatf("pix(%0d,%0d) mode%0d", h, v, m_mode), bus.Disp_Data, exp);
        check("mode", {14'b0, bus.Mode}, 16'(m_mode));
    endtask

    task automatic goto_mode(int target);
        for (int i = 0; i < 4 && m_mode != target; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        int h, v;
        model_reset();
        for (int i = 0; i < 3; i++) cyc(1, 5, 5, 0, 0, 0, 1);

        // Bars, latency and out-of-range requests.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 99, 10, 0, 0, 0, 0);
        cyc(1, 100, 10, 0, 0, 0, 0);
        cyc(1, 799, 479, 0, 0, 0, 0);
        cyc(1, 800, 0, 0, 0, 0, 0);
        cyc(1, 10, 480, 0, 0, 0, 0);
        cyc(0, 10, 10, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, i * 100 + 50, 7, 0, 0, 0, 0);

        // Auto-advance and hold.
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 0, 0);

        // Gradient and checkerboard.
        goto_mode(1);
        cyc(1, 255, 0, 0, 0, 0, 0);
        cyc(1, 256, 0, 0, 0, 0, 0);
        cyc(1, 100, 9, 0, 0, 0, 0);
        goto_mode(2);
        cyc(1, 32, 0, 0, 0, 0, 0);
        cyc(1, 32, 32, 0, 0, 0, 0);

        // Mode_Next coincident with a rollover, then a full count to the next advance.
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0);

        // Bounce the box across both walls with mode held on BOX.
        goto_mode(3);
        for (int f = 0; f < 260; f++) begin
            cyc(0, 0, 0, 1, 1, 0, 0);
            for (int k = 0; k < 4; k++) begin
                h = m_bx + int'($urandom_range(0, 76)) - 4;
                v = m_by + int'($urandom_range(0, 76)) - 4;
                if (h < 0) h = 0;
                if (v < 0) v = 0;
                cyc(1, h, v, 0, 1, 0, 0);
            end
        end

        // Unconstrained random traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 850)),
                int'($urandom_range(0, 500)), $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0, 0);
        end

        // Reset in the middle of a frame.
        cyc(1, 300, 300, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        goto_mode(3);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 63, 63, 0, 0, 0, 0);
        cyc(1, 64, 0, 0, 0, 0, 0);

        // Border pixels in checkerboard mode.
        goto_mode(2);
        cyc(1, 0, 200, 0, 0, 0, 0);
        cyc(1, 400, 479, 0, 0, 0, 0);
        cyc(1, 799, 100, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
